// File: rtl/uart_param.sv
// Parameterised UART: independent TX and RX with configurable data width,
// parity (none/even/odd) and 1 or 2 stop bits, fixed integer clock divider.
`timescale 1ns/1ps
module uart_param #(
  parameter int unsigned clk_freq    = 50000000,
  parameter int unsigned baud_rate   = 19200,
  parameter int unsigned data_bits   = 8,
  parameter int unsigned parity_mode = 0,
  parameter int unsigned stop_bits   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [data_bits-1:0] tx_data_in,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_active,
  output logic                 done_tx,
  output logic [data_bits-1:0] rx_data_out,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);
  localparam int unsigned DIV  = clk_freq / baud_rate;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [2:0]    BIT_LAST = 3'(data_bits - 1);
  localparam logic          ODD      = (parity_mode == 2);
  localparam logic          HAS_PAR  = (parity_mode != 0);
  localparam logic          STOP_LAST = (stop_bits == 2);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  tx_state_t            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic                 tx_stop_q, tx_stop_d;
  logic [data_bits-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_active_q, tx_active_d;
  logic                 done_tx_q, done_tx_d;
  logic                 tx_tick;

  rx_state_t            rx_state_q, rx_state_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [data_bits-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic [data_bits-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_tick;

  assign tx_tick = (tx_cnt_q == CNT_LAST);
  assign rx_tick = (rx_cnt_q == CNT_LAST);

  // tx_d holds the level for the next bit so the line changes exactly on bit boundaries
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_tick ? '0 : tx_cnt_q + CW'(1);
    tx_bit_d    = tx_bit_q;
    tx_stop_d   = tx_stop_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    tx_d        = tx_q;
    tx_active_d = tx_active_q;
    done_tx_d   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_valid) begin
          tx_shift_d  = tx_data_in;
          tx_par_d    = ^tx_data_in ^ ODD;
          tx_state_d  = TX_START;
          tx_d        = 1'b0;
          tx_active_d = 1'b1;
        end
      end
      TX_START: if (tx_tick) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
      end
      TX_DATA: if (tx_tick) begin
        if (tx_bit_q == BIT_LAST) begin
          tx_stop_d = 1'b0;
          if (HAS_PAR) begin
            tx_state_d = TX_PARITY;
            tx_d       = tx_par_q;
          end else begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = tx_shift_q >> 1;
          tx_d       = tx_shift_q[1];
        end
      end
      TX_PARITY: if (tx_tick) begin
        tx_state_d = TX_STOP;
        tx_d       = 1'b1;
      end
      TX_STOP: begin
        if (tx_stop_q == STOP_LAST && tx_cnt_q == CNT_PRE) done_tx_d = 1'b1;
        if (tx_tick) begin
          if (tx_stop_q == STOP_LAST) begin
            tx_state_d  = TX_IDLE;
            tx_active_d = 1'b0;
          end else begin
            tx_stop_d = 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_stop_q   <= 1'b0;
      tx_shift_q  <= '0;
      tx_par_q    <= 1'b0;
      tx_q        <= 1'b1;
      tx_active_q <= 1'b0;
      done_tx_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_stop_q   <= tx_stop_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_q    <= tx_par_d;
      tx_q        <= tx_d;
      tx_active_q <= tx_active_d;
      done_tx_q   <= done_tx_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_tick ? '0 : rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == CNT_HALF) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_tick) begin
        rx_shift_d = {rx_sync_q, rx_shift_q[data_bits-1:1]};
        if (rx_bit_q == BIT_LAST) rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
        else rx_bit_d = rx_bit_q + 3'd1;
      end
      RX_PARITY: if (rx_tick) begin
        rx_par_d   = rx_sync_q;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_tick) begin
        rx_valid_d = 1'b1;
        rx_data_d  = rx_shift_q;
        rx_perr_d  = HAS_PAR && (rx_par_q != (^rx_shift_q ^ ODD));
        rx_ferr_d  = !rx_sync_q;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: begin
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign tx_ready      = (tx_state_q == TX_IDLE);
  assign tx            = tx_q;
  assign tx_active     = tx_active_q;
  assign done_tx       = done_tx_q;
  assign rx_data_out   = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
endmodule

// File: doc/uart_param.md
UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 Parameter: clk_freq, default 50000000, clock frequency in Hz.
REQ-002 Parameter: baud_rate, default 19200, line rate in bits/s; clock_divide = clk_freq/baud_rate (integer, >=4).
REQ-003 Parameter: data_bits, default 8, legal 5..8, payload bits per frame.
REQ-004 Parameter: parity_mode, default 0; 0 = none, 1 = even, 2 = odd.
REQ-005 Parameter: stop_bits, default 1, legal 1..2.
REQ-006 Port: clk  input  1  single clock for all logic.
REQ-007 Port: rst  input  1  reset, asynchronous, active-high.
REQ-008 Port: rx  input  1  serial receive line, asynchronous to clk.
REQ-009 Port: tx_data_in  input  data_bits  transmit payload.
REQ-010 Port: tx_valid  input  1  transmit request.
REQ-011 Port: tx_ready  output  1  transmitter idle and able to accept a payload.
REQ-012 Port: tx  output  1  serial transmit line, idle high.
REQ-013 Port: tx_active  output  1  high while a frame is on the line.
REQ-014 Port: done_tx  output  1  one-cycle pulse at frame end.
REQ-015 Port: rx_data_out  output  data_bits  last received payload.
REQ-016 Port: rx_valid  output  1  one-cycle pulse when rx_data_out and the error flags update.
REQ-017 Port: rx_parity_err  output  1  parity mismatch on the last frame.
REQ-018 Port: rx_frame_err  output  1  first stop bit sampled low on the last frame.

Function
REQ-019 Frame format SHALL be: start (0), data LSB first, optional parity bit, stop_bits x 1; every bit lasts exactly clock_divide cycles.
REQ-020 Parity bit SHALL be the XOR of the data bits for even parity, and its inverse for odd parity.
REQ-021 TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when parity_mode=0.
REQ-022 Handshake: a payload is accepted on a cycle with tx_valid=1 and tx_ready=1; tx_ready=1 only in IDLE.
REQ-023 tx_data_in SHALL be latched at acceptance; later changes SHALL NOT affect the frame in progress.
REQ-024 tx SHALL go low on the cycle after acceptance; tx_active SHALL be high from that cycle through the last stop-bit cycle.
REQ-025 done_tx SHALL pulse in the final cycle of the last stop bit; tx_ready SHALL be high the following cycle.
REQ-026 Back-to-back frames: if tx_valid is held high, the next start bit SHALL begin 1 cycle after tx_ready rises.
REQ-027 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-028 RX FSM SHALL use states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-029 In IDLE, a synchronized falling edge SHALL start a counter; the line SHALL be resampled at clock_divide/2 cycles.
REQ-030 If the start-bit resample is high, the glitch SHALL be discarded: return to IDLE, no rx_valid.
REQ-031 Each subsequent bit SHALL be sampled once, clock_divide cycles after the previous sample.
REQ-032 Only the first stop bit SHALL be checked.
REQ-033 At the stop sample, in the next cycle: rx_data_out updates, flags update, rx_valid pulses.
REQ-034 rx_parity_err SHALL be 0 when parity_mode=0.
REQ-035 If the stop sample is 0 (frame error or break), the FSM SHALL enter WAIT_HIGH and return to IDLE only after the synchronized line is high.
REQ-036 Data SHALL still be delivered on a frame error.
REQ-037 TX and RX SHALL operate independently; simultaneous activity SHALL be allowed, including a loopback of tx to rx.

Reset
REQ-038 While rst=1, the block SHALL hold: tx=1, tx_ready=1, tx_active=0, done_tx=0, rx_data_out=0, rx_valid=0, rx_parity_err=0, rx_frame_err=0, both FSMs IDLE, all counters 0.
REQ-039 Reset asserted mid-frame SHALL force tx=1 immediately, without waiting for a clock edge.
REQ-040 Reset asserted mid-frame SHALL abandon any partial RX frame without an rx_valid pulse.

Verification
REQ-041 Scenario (clock_divide=16, 8N1): send 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1, each 16 cycles; done_tx at cycle 160 after acceptance.
REQ-042 Scenario: loopback tx->rx, 8E1, payloads 0x00, 0xFF, 0x3C back-to-back -> three rx_valid pulses, data equal, rx_parity_err=0.
REQ-043 Scenario: 7O2, drive a frame with the parity bit inverted -> rx_valid with rx_parity_err=1, data intact.
REQ-044 Scenario: rx held low 40 bit-times (break) -> one rx_valid with rx_data_out=0, rx_frame_err=1; no further rx_valid until rx returns high plus a new start bit.
REQ-045 Scenario: rx low pulse of 5 cycles (< clock_divide/2) -> no rx_valid, RX FSM returns to IDLE.
REQ-046 Scenario: rst asserted mid-DATA during TX and RX -> tx=1 asynchronously, tx_ready=1 after release, no done_tx and no rx_valid for the aborted frames.
